// File: rtl/gerador_tom.sv
// rtl/gerador_tom.sv - square-wave tone generator driven by a one-hot note bus
//
// Ports:
//   clock   in   1   system clock, rising edge
//   reset   in   1   synchronous active-high reset
//   nota    in  12   one-hot note C4..B4 (bit 0 = C4); zero or multi-bit = silence
//   oitava  in   2   octave shift 0..3 (only with GERADOR_TOM_OITAVA_EN defined)
//   buzzer  out  1   50 % duty square wave at the selected note frequency
//   tocando out  1   high while a valid note is being generated
//
// Optional feature macro: GERADOR_TOM_OITAVA_EN
module gerador_tom #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int CNT_W    = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] nota,
`ifdef GERADOR_TOM_OITAVA_EN
    input  logic [1:0]  oitava,
`endif
    output logic        buzzer,
    output logic        tocando
);

    // CLK_FREQ*50 overflows 32 bits at realistic clock rates, so the division
    // is carried out in 64 bits before truncating to the counter width.
    function automatic logic [CNT_W-1:0] half_of(input logic [63:0] fch);
        return CNT_W'((64'(CLK_FREQ) * 64'd50) / fch);
    endfunction

    localparam logic [CNT_W-1:0] HALF [12] = '{
        half_of(64'd26163), half_of(64'd27718), half_of(64'd29366),
        half_of(64'd31113), half_of(64'd32963), half_of(64'd34923),
        half_of(64'd36999), half_of(64'd39200), half_of(64'd41530),
        half_of(64'd44000), half_of(64'd46616), half_of(64'd49388)
    };

    typedef enum logic {
        SILENCIO = 1'b0,
        TOCANDO  = 1'b1
    } estado_t;

    estado_t          state;
    estado_t          state_next;
    logic [11:0]      nota_r;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_sel;
    logic [CNT_W-1:0] half_eff;
    logic             nota_valid;
    logic             change;

`ifdef GERADOR_TOM_OITAVA_EN
    logic [1:0]       oitava_r;
    assign change   = (nota != nota_r) || (oitava != oitava_r);
    assign half_eff = half_sel >> oitava_r;
`else
    assign change   = (nota != nota_r);
    assign half_eff = half_sel;
`endif

    assign nota_valid = $onehot(nota);
    assign tocando    = (state == TOCANDO);

    // nota_r is one-hot whenever the state is TOCANDO, so an OR-select is
    // enough to pick the half-period without an encoder.
    always_comb begin
        half_sel = '0;
        for (int i = 0; i < 12; i++) begin
            if (nota_r[i]) begin
                half_sel = half_sel | HALF[i];
            end
        end
    end

    always_comb begin
        state_next = state;
        if (change) begin
            state_next = nota_valid ? TOCANDO : SILENCIO;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= SILENCIO;
            nota_r <= '0;
            cnt    <= '0;
            buzzer <= 1'b0;
`ifdef GERADOR_TOM_OITAVA_EN
            oitava_r <= '0;
`endif
        end else begin
            state <= state_next;
            if (change) begin
                // Any change restarts the phase, including at a wrap edge.
                nota_r <= nota;
                cnt    <= '0;
                buzzer <= 1'b0;
`ifdef GERADOR_TOM_OITAVA_EN
                oitava_r <= oitava;
`endif
            end else if (state == TOCANDO) begin
                if (cnt == half_eff - CNT_W'(1)) begin
                    cnt    <= '0;
                    buzzer <= ~buzzer;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt    <= '0;
                buzzer <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gerador_tom.sv
// tb/tb_gerador_tom.sv - directed self-checking bench for gerador_tom
module tb_gerador_tom;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] nota;
`ifdef GERADOR_TOM_OITAVA_EN
    logic [1:0]  oitava;
`endif
    logic        buzzer;
    logic        tocando;

    int checks = 0;
    int fails  = 0;
    int n;

    gerador_tom #(
        .CLK_FREQ(1_000_000),
        .CNT_W   (20)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .nota   (nota),
`ifdef GERADOR_TOM_OITAVA_EN
        .oitava (oitava),
`endif
        .buzzer (buzzer),
        .tocando(tocando)
    );

    always #5 clock = ~clock;

    task automatic step(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Edges until buzzer reaches v; bounded so a dead output cannot hang the run.
    task automatic count_until(input logic v, output int cnt);
        cnt = 0;
        do begin
            step(1);
            cnt++;
        end while (buzzer !== v && cnt < 5000);
    endtask

    initial begin
        reset = 1'b1;
        nota  = 12'h000;
`ifdef GERADOR_TOM_OITAVA_EN
        oitava = 2'd0;
`endif
        step(2);
        check("reset_buzzer", 32'(buzzer), 0);
        check("reset_tocando", 32'(tocando), 0);
        reset = 1'b0;

        // A4: HALF = 50e6/44000 = 1136
        nota = 12'h200;
        step(1);
        check("a4_tocando", 32'(tocando), 1);
        check("a4_buzzer_low", 32'(buzzer), 0);
        count_until(1'b1, n);
        check("a4_first_rise", n, 1136);
        for (int p = 0; p < 5; p++) begin
            int a, b;
            count_until(1'b0, a);
            count_until(1'b1, b);
            check($sformatf("a4_period_%0d", p), a + b, 2272);
        end

        // C4 (1911) then B4 (1012) during the high phase
        nota = 12'h001;
        step(1);
        check("c4_tocando", 32'(tocando), 1);
        count_until(1'b1, n);
        check("c4_first_rise", n, 1911);
        step(100);
        nota = 12'h800;
        step(1);
        check("b4_change_buzzer", 32'(buzzer), 0);
        check("b4_change_tocando", 32'(tocando), 1);
        count_until(1'b1, n);
        check("b4_first_rise", n, 1012);
        count_until(1'b0, n);
        check("b4_half", n, 1012);

        // silence with zero, then with a multi-bit pattern
        count_until(1'b1, n);
        nota = 12'h000;
        step(1);
        check("zero_buzzer", 32'(buzzer), 0);
        check("zero_tocando", 32'(tocando), 0);
        step(50);
        check("zero_hold_buzzer", 32'(buzzer), 0);
        check("zero_hold_tocando", 32'(tocando), 0);
        nota = 12'h0C0;
        step(1);
        check("multi_tocando", 32'(tocando), 0);
        step(3000);
        check("multi_hold_buzzer", 32'(buzzer), 0);
        check("multi_hold_tocando", 32'(tocando), 0);

        // E4: HALF 1516
        nota = 12'h010;
        step(1);
        check("e4_tocando", 32'(tocando), 1);
        count_until(1'b1, n);
        check("e4_first_rise", n, 1516);

        // reset mid-A4, then restart from phase 0
        nota = 12'h200;
        step(1);
        count_until(1'b1, n);
        check("a4b_first_rise", n, 1136);
        step(10);
        reset = 1'b1;
        step(1);
        check("midreset_buzzer", 32'(buzzer), 0);
        check("midreset_tocando", 32'(tocando), 0);
        reset = 1'b0;
        step(1);
        check("restart_tocando", 32'(tocando), 1);
        check("restart_buzzer", 32'(buzzer), 0);
        count_until(1'b1, n);
        check("restart_first_rise", n, 1136);

        // one-cycle glitch: two change events, phase restarts from the second
        step(20);
        nota = 12'h800;
        step(1);
        nota = 12'h200;
        step(1);
        check("glitch_buzzer", 32'(buzzer), 0);
        check("glitch_tocando", 32'(tocando), 1);
        count_until(1'b1, n);
        check("glitch_first_rise", n, 1136);

`ifdef GERADOR_TOM_OITAVA_EN
        oitava = 2'd2;
        step(1);
        check("oit2_buzzer", 32'(buzzer), 0);
        check("oit2_tocando", 32'(tocando), 1);
        count_until(1'b1, n);
        check("oit2_first_rise", n, 284);
        step(5);
        oitava = 2'd1;
        step(1);
        check("oit1_buzzer", 32'(buzzer), 0);
        check("oit1_tocando", 32'(tocando), 1);
        count_until(1'b1, n);
        check("oit1_first_rise", n, 568);
        count_until(1'b0, n);
        check("oit1_half", n, 568);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/gerador_tom.md
# gerador_tom

Square-wave tone generator for the buzzer. It sits directly downstream of the note decoder and consumes its 12-bit one-hot `nota` bus, one bit per semitone C4..B4 (bit 0 = C4, bit 11 = B4). While a single valid note is present it drives `buzzer` with a 50 % duty square wave at that note's frequency. It is silent otherwise.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz; sets every half-period.
- `CNT_W`, default 20: half-period counter width; must hold the largest half-period (C4).
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `nota`  in  12  one-hot note from the decoder; all-zero means silence.
- `oitava`  in  2  octave shift, 0..3; present only with `GERADOR_TOM_OITAVA_EN`.
- `buzzer`  out  1  square-wave output to the buzzer.
- `tocando`  out  1  high while a valid note is being generated.

## Operation
- Note frequencies are fixed constants in centihertz, bit 0..11: 26163, 27718, 29366, 31113, 32963, 34923, 36999, 39200, 41530, 44000, 46616, 49388.
- Half-period `HALF[i] = (CLK_FREQ*50) / FCH[i]`.
  - Integer truncation.
  - Evaluated with 64-bit elaboration arithmetic, because `CLK_FREQ*50` overflows 32 bits.
- `nota` is valid only when exactly one bit is set. All-zero or any multi-bit pattern is invalid and gives silence.
- Registered copy `nota_r`; 2-state FSM with states SILENCIO and TOCANDO.
- At every edge where `nota != nota_r` (the "change event"):
  - `nota_r <= nota`, counter <= 0, `buzzer <= 0`.
  - The state becomes TOCANDO if `nota` is valid, else SILENCIO.
- SILENCIO:
  - `buzzer = 0`, `tocando = 0`, counter held at 0.
- TOCANDO, with no change event:
  - Counter increments each edge.
  - At the edge where counter == `HALF[sel]-1`, `buzzer` toggles and the counter wraps to 0.
- The active half-period is fixed while the note is stable. A change event at a wrap edge takes priority: counter 0, `buzzer` 0.
- The same note held indefinitely plays continuously, with no phase discontinuity.
- `tocando` is a registered output: 1 exactly when the state is TOCANDO.

## Timing
- Reset, at any time including mid-tone, takes effect at the next edge:
  - `buzzer = 0`, `tocando = 0`, counter = 0, `nota_r = 0`, state SILENCIO.
- Latency: a note applied before edge E0 gives `tocando = 1` after E0.
- With the note held from E0, the first `buzzer` rise is at edge E0 + HALF, and the output then toggles every HALF edges.
- Period is `2*HALF` clocks, exact; no drift across periods.
- Silence latency: an invalid or zero `nota` before edge E forces `buzzer = 0` and `tocando = 0` after E.
- A note-to-note change restarts the phase with one cycle of latency. `tocando` stays 1, with no glitch.
- A glitch on `nota` lasting one cycle counts as two change events. Each one restarts the phase.

## Configuration
- `GERADOR_TOM_OITAVA_EN` defined:
  - Port `oitava[1:0]` exists, and the effective half-period is `HALF[i] >> oitava`.
  - `oitava` is registered alongside `nota`. A change in `oitava` is a change event, with identical restart behaviour.
- Undefined:
  - Port `oitava` is absent, and the shift is fixed at 0.
  - Counter and compare logic for the shift is not generated.

## Test plan
All scenarios run with `CLK_FREQ = 1_000_000`.

- Reset then `nota = 12'h200` (A4):
  - `tocando` is 1 after the first edge.
  - `buzzer` rises 1136 edges later.
  - Period is 2272 clocks over 5 periods.
- `nota = 12'h001` (C4), then `12'h800` (B4) mid-high-phase:
  - Next edge: `buzzer = 0`, `tocando` stays 1.
  - HALF changes from 1911 to 1012, with the first rise 1012 edges after the change.
- `nota = 12'h000` or `12'h0C0`:
  - `buzzer = 0` and `tocando = 0` after one edge, and both stay there.
  - A following `12'h010` (E4) gives HALF 1516.
- `reset` asserted for one cycle mid-A4:
  - All outputs are 0 at the next edge.
  - With A4 still applied, the tone restarts from phase 0.
- With `GERADOR_TOM_OITAVA_EN` defined:
  - A4 with `oitava = 2` gives a half-period of 284.
  - Changing `oitava` to 1 mid-tone restarts the phase, giving a half-period of 568.
